// File: rtl/mem_bus_sequencer.sv
// Converts single-cycle word requests into the multiplexed SRAM pad protocol:
// chained 7-bit address-latch strobes, then a strobed nibble data phase per beat.
module mem_bus_sequencer #(
  parameter int ADDR_W     = 7,
  parameter int BEATS_LOG2 = 0,
  parameter int SETTLE     = 1,
  localparam int DATA_W    = 4 << BEATS_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        pad_out,
  input  logic [3:0]        pad_in,
  output logic [2:0]        state_dbg
);
  // Handshake: a request transfers on a rising edge where req && ready;
  // ready is high in IDLE and in the one-cycle DONE (ack) state.
  localparam int NA_W = ADDR_W + BEATS_LOG2;
  localparam int NA   = (NA_W + 6) / 7;
  localparam int NB   = 1 << BEATS_LOG2;
  localparam int BW   = (BEATS_LOG2 > 0) ? BEATS_LOG2 : 1;
  localparam int LA_W = NA * 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_RECOV = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [2:0]          phase_q, phase_d;
  logic [3:0]          settle_q, settle_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [LA_W-1:0]     na;
  logic [3:0]          wnib;
  logic [DATA_W-1:0]   rd_merged;
  logic                last_beat;
  logic                beat_end;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    beat_d    = beat_q;
    phase_d   = phase_q;
    settle_d  = settle_q;
    rbuf_d    = rbuf_q;
    rdata_d   = rdata_q;
    ready     = 1'b0;
    ack       = 1'b0;
    pad_out   = 8'h30;
    beat_end  = 1'b0;
    na        = (LA_W'(addr_q) << BEATS_LOG2) | LA_W'(beat_q);
    wnib      = 4'(wdata_q >> (4 * beat_q));
    last_beat = (beat_q == BW'(NB - 1));
    rd_merged = (rbuf_q & ~(DATA_W'(4'hF) << (4 * beat_q)))
              | (DATA_W'(pad_in) << (4 * beat_q));

    case (state_q)
      S_IDLE, S_DONE: begin
        ready   = 1'b1;
        ack     = (state_q == S_DONE);
        state_d = S_IDLE;
        if (req) begin
          state_d  = S_ADDR;
          we_d     = we;
          addr_d   = addr;
          wdata_d  = wdata;
          beat_d   = '0;
          phase_d  = '0;
          settle_d = '0;
        end
      end
      S_ADDR: begin
        // Most-significant chunk first; the external latch chain shifts per strobe.
        pad_out = {1'b1, 7'(na >> (7 * (NA - 1 - int'(phase_q))))};
        if (phase_q == 3'(NA - 1)) begin
          phase_d  = '0;
          settle_d = '0;
          state_d  = S_DATA;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      S_DATA: begin
        pad_out = we_q ? {4'b0001, wnib} : 8'h20;
        if (settle_q == 4'(SETTLE - 1)) begin
          if (we_q) begin
            state_d = S_RECOV;
          end else begin
            rbuf_d   = rd_merged;
            beat_end = 1'b1;
            if (last_beat) rdata_d = rd_merged;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_RECOV: begin
        pad_out  = {4'b0011, wnib};
        beat_end = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Beat counter wraps inside the word; it never carries into the address.
    if (beat_end) begin
      if (last_beat) begin
        state_d = S_DONE;
        beat_d  = '0;
      end else begin
        state_d = S_ADDR;
        beat_d  = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      beat_q   <= '0;
      phase_q  <= '0;
      settle_q <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      beat_q   <= beat_d;
      phase_q  <= phase_d;
      settle_q <= settle_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: a default instance and a wide-word instance, each
// with a small SRAM model, pad/ack scoreboards and a protocol monitor.
module tb_mem_bus_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: ADDR_W=7, BEATS_LOG2=0, SETTLE=1
  logic       a_req, a_we, a_ready, a_ack;
  logic [6:0] a_addr;
  logic [3:0] a_wdata, a_rdata, a_pin;
  logic [7:0] a_pad;
  logic [2:0] a_st;

  mem_bus_sequencer dut_a (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .ready(a_ready), .ack(a_ack), .rdata(a_rdata), .pad_out(a_pad), .pad_in(a_pin),
    .state_dbg(a_st)
  );

  // ---------------- instance B: ADDR_W=10, BEATS_LOG2=2, SETTLE=2
  logic        b_req, b_we, b_ready, b_ack;
  logic [9:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [3:0]  b_pin;
  logic [7:0]  b_pad;
  logic [2:0]  b_st;

  mem_bus_sequencer #(.ADDR_W(10), .BEATS_LOG2(2), .SETTLE(2)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .ready(b_ready), .ack(b_ack), .rdata(b_rdata), .pad_out(b_pad), .pad_in(b_pin),
    .state_dbg(b_st)
  );

  // SRAM models: latch chain shifts on strobe, write while nWE low, drive while nRD low.
  logic [6:0]  a_lat = '0;
  logic [3:0]  a_mem [128];
  logic [13:0] b_lat = '0;
  logic [3:0]  b_mem [16384];

  always @(posedge clk) begin
    if (a_pad[7]) a_lat <= a_pad[6:0];
    else if (!a_pad[5]) a_mem[a_lat] <= a_pad[3:0];
    if (b_pad[7]) b_lat <= {b_lat[6:0], b_pad[6:0]};
    else if (!b_pad[5]) b_mem[b_lat] <= b_pad[3:0];
  end
  assign a_pin = (!a_pad[7] && !a_pad[4]) ? a_mem[a_lat] : 4'h0;
  assign b_pin = (!b_pad[7] && !b_pad[4]) ? b_mem[b_lat] : 4'h0;

  // Scoreboards: expected pad bytes per busy cycle, and {check_rdata, latency, rdata} per ack.
  logic [7:0]  a_pad_q[$];
  logic [31:0] a_exp_q[$];
  logic [7:0]  b_pad_q[$];
  logic [31:0] b_exp_q[$];
  logic [31:0] a_e, b_e;
  int  a_acc = 0, b_acc = 0, a_acks = 0, b_acks = 0;
  logic a_ackp = 1'b0, b_ackp = 1'b0;
  bit  a_mon = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (!a_pad[7]) chk("a_strobe_excl", 32'(a_pad[5] | a_pad[4]), 1);
      if (a_ack) begin
        a_acks++;
        chk("a_ack_width", 32'(a_ackp), 0);
        if (a_mon) begin
          if (a_exp_q.size() == 0) chk("a_ack_unexpected", 1, 0);
          else begin
            a_e = a_exp_q.pop_front();
            chk("a_latency", cyc - a_acc + 1, {24'h0, a_e[23:16]});
            if (a_e[31]) chk("a_rdata", 32'(a_rdata), {16'h0, a_e[15:0]});
          end
        end
      end
      if (a_mon) begin
        if (!a_ready) begin
          if (a_pad_q.size() == 0) chk("a_pad_extra", 32'(a_pad), 0);
          else chk("a_pad_seq", 32'(a_pad), 32'(a_pad_q.pop_front()));
        end else chk("a_pad_idle", 32'(a_pad), 32'h30);
      end
      if (a_req && a_ready) a_acc = cyc + 1;
    end
    a_ackp = a_ack;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!b_pad[7]) chk("b_strobe_excl", 32'(b_pad[5] | b_pad[4]), 1);
      if (b_ack) begin
        b_acks++;
        chk("b_ack_width", 32'(b_ackp), 0);
        if (b_exp_q.size() == 0) chk("b_ack_unexpected", 1, 0);
        else begin
          b_e = b_exp_q.pop_front();
          chk("b_latency", cyc - b_acc + 1, {24'h0, b_e[23:16]});
          if (b_e[31]) chk("b_rdata", 32'(b_rdata), {16'h0, b_e[15:0]});
        end
      end
      if (!b_ready) begin
        if (b_pad_q.size() == 0) chk("b_pad_extra", 32'(b_pad), 0);
        else chk("b_pad_seq", 32'(b_pad), 32'(b_pad_q.pop_front()));
      end else chk("b_pad_idle", 32'(b_pad), 32'h30);
      if (b_req && b_ready) b_acc = cyc + 1;
    end
    b_ackp = b_ack;
  end

  // ---------------- driver tasks
  task automatic a_issue(input logic we, input logic [6:0] ad, input logic [3:0] wd);
    int n = 0;
    while (!a_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("a_ready_timeout", 1, 0);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic b_issue(input logic we, input logic [9:0] ad, input logic [15:0] wd);
    int n = 0;
    while (!b_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("b_ready_timeout", 1, 0);
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  task automatic a_push3(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    a_pad_q.push_back(p0); a_pad_q.push_back(p1); a_pad_q.push_back(p2);
  endtask

  // Wide-word expectations: high chunk, low chunk of beat 0 (incremented per beat), nibbles lsb first.
  task automatic b_push(input logic we, input logic [7:0] hi, input logic [7:0] lo0,
                        input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      b_pad_q.push_back(hi);
      b_pad_q.push_back(lo0 + 8'(i));
      if (we) begin
        b_pad_q.push_back({4'h1, w[4*i +: 4]});
        b_pad_q.push_back({4'h1, w[4*i +: 4]});
        b_pad_q.push_back({4'h3, w[4*i +: 4]});
      end else begin
        b_pad_q.push_back(8'h20);
        b_pad_q.push_back(8'h20);
      end
    end
  endtask

  task automatic drain;
    int n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  int acks0;
  int n;

  initial begin
    for (int i = 0; i < 128; i++) a_mem[i] = 4'h0;
    for (int i = 0; i < 16384; i++) b_mem[i] = 4'h0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_a_ready", 32'(a_ready), 1);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_a_pad", 32'(a_pad), 32'h30);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_a_state", 32'(a_st), 0);
    chk("rst_b_pad", 32'(b_pad), 32'h30);
    chk("rst_b_rdata", 32'(b_rdata), 0);

    // Default write then read-back at 0x5E.
    a_push3(8'hDE, 8'h19, 8'h39);
    a_exp_q.push_back({1'b0, 7'h0, 8'd4, 16'h0});
    a_issue(1'b1, 7'h5E, 4'h9);
    drain();
    chk("a_sram_5e", 32'(a_mem[7'h5E]), 9);

    a_pad_q.push_back(8'hDE); a_pad_q.push_back(8'h20);
    a_exp_q.push_back({1'b1, 7'h0, 8'd3, 16'h9});
    a_issue(1'b0, 7'h5E, 4'h0);
    drain();

    a_push3(8'hA1, 8'h16, 8'h36);
    a_exp_q.push_back({1'b0, 7'h0, 8'd4, 16'h0});
    a_issue(1'b1, 7'h21, 4'h6);
    a_pad_q.push_back(8'hA1); a_pad_q.push_back(8'h20);
    a_exp_q.push_back({1'b1, 7'h0, 8'd3, 16'h6});
    a_issue(1'b0, 7'h21, 4'h0);
    drain();

    // Reset held two cycles in the middle of a write.
    a_mon = 1'b0;
    a_issue(1'b1, 7'h11, 4'h3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pad", 32'(a_pad), 32'h30);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", 32'(a_ready), 1);
    chk("mid_rst_ack", 32'(a_ack), 0);
    chk("mid_rst_rdata", 32'(a_rdata), 0);
    chk("mid_rst_state", 32'(a_st), 0);
    acks0 = a_acks;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_pad", 32'(a_pad), 32'h30);
    end
    chk("post_rst_no_ack", a_acks - acks0, 0);
    a_mon = 1'b1;

    // Back-to-back with req held high: read accepted in the write's ack cycle.
    a_push3(8'hB3, 8'h1C, 8'h3C);
    a_pad_q.push_back(8'hB3); a_pad_q.push_back(8'h20);
    a_exp_q.push_back({1'b0, 7'h0, 8'd4, 16'h0});
    a_exp_q.push_back({1'b1, 7'h0, 8'd3, 16'hC});
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h33; a_wdata = 4'hC;
    @(posedge clk); #1;
    a_we = 1'b0; a_wdata = 4'h0;
    n = 0;
    while (!a_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2b_accept_in_ack", 32'(a_ack), 1);
    @(posedge clk); #1;
    a_req = 1'b0;
    drain();

    // Request pulses while busy must be ignored: exactly two acks.
    acks0 = a_acks;
    a_push3(8'hC4, 8'h15, 8'h35);
    a_pad_q.push_back(8'hC4); a_pad_q.push_back(8'h20);
    a_exp_q.push_back({1'b0, 7'h0, 8'd4, 16'h0});
    a_exp_q.push_back({1'b1, 7'h0, 8'd3, 16'h5});
    a_issue(1'b1, 7'h44, 4'h5);
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h7F; a_wdata = 4'hF;
    @(posedge clk); #1;
    a_req = 1'b0;
    @(posedge clk); #1;
    a_req = 1'b1;
    @(posedge clk); #1;
    a_req = 1'b0;
    a_issue(1'b0, 7'h44, 4'h0);
    drain();
    chk("busy_two_acks", a_acks - acks0, 2);
    chk("a_sram_7f_untouched", 32'(a_mem[7'h7F]), 0);

    // Wide word: 4 beats, two address phases, SETTLE=2.
    b_push(1'b1, 8'h9F, 8'hFC, 16'hA5C3);
    b_exp_q.push_back({1'b0, 7'h0, 8'd21, 16'h0});
    b_issue(1'b1, 10'h3FF, 16'hA5C3);
    drain();
    chk("b_sram_ffc", 32'(b_mem[14'h0FFC]), 32'h3);
    chk("b_sram_fff", 32'(b_mem[14'h0FFF]), 32'hA);

    b_push(1'b0, 8'h9F, 8'hFC, 16'h0);
    b_exp_q.push_back({1'b1, 7'h0, 8'd17, 16'hA5C3});
    b_issue(1'b0, 10'h3FF, 16'h0);
    drain();

    b_push(1'b1, 8'h80, 8'h84, 16'h1234);
    b_exp_q.push_back({1'b0, 7'h0, 8'd21, 16'h0});
    b_issue(1'b1, 10'h001, 16'h1234);
    b_push(1'b0, 8'h80, 8'h84, 16'h0);
    b_exp_q.push_back({1'b1, 7'h0, 8'd17, 16'h1234});
    b_issue(1'b0, 10'h001, 16'h0);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("a_pad_q_empty", a_pad_q.size(), 0);
    chk("b_pad_q_empty", b_pad_q.size(), 0);
    chk("a_exp_q_empty", a_exp_q.size(), 0);
    chk("b_exp_q_empty", b_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
